// File: rtl/axi_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_master
// Purpose  : Single-outstanding AXI4 master; one request becomes one INCR
//            burst and finishes with one completion pulse and merged response.
// Revision : 1.0 - initial release
// ============================================================================
module axi_burst_master #(
    parameter int ID_W      = 4,
    parameter int MASTER_ID = 0,
    parameter int LEN_W     = 4
) (
    input  logic             ACLK,
    input  logic             ARESET,
    // request port
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [31:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    // write-data stream
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_strb,
    // read-data stream
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [31:0]      rd_data,
    output logic             rd_last,
    // completion
    output logic             done,
    output logic [1:0]       done_resp,
    // AXI read address
    output logic [ID_W-1:0]  ARID,
    output logic [31:0]      ARADDR,
    output logic [LEN_W-1:0] ARLEN,
    output logic [2:0]       ARSIZE,
    output logic [1:0]       ARBURST,
    output logic             ARVALID,
    input  logic             ARREADY,
    // AXI read data
    input  logic [ID_W-1:0]  RID,
    input  logic [31:0]      RDATA,
    input  logic [1:0]       RRESP,
    input  logic             RLAST,
    input  logic             RVALID,
    output logic             RREADY,
    // AXI write address
    output logic [ID_W-1:0]  AWID,
    output logic [31:0]      AWADDR,
    output logic [LEN_W-1:0] AWLEN,
    output logic [2:0]       AWSIZE,
    output logic [1:0]       AWBURST,
    output logic             AWVALID,
    input  logic             AWREADY,
    // AXI write data
    output logic [31:0]      WDATA,
    output logic [3:0]       WSTRB,
    output logic             WLAST,
    output logic             WVALID,
    input  logic             WREADY,
    // AXI write response
    input  logic [ID_W-1:0]  BID,
    input  logic [1:0]       BRESP,
    input  logic             BVALID,
    output logic             BREADY
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_AW   = 3'd3;
    localparam logic [2:0] S_W    = 3'd4;
    localparam logic [2:0] S_B    = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         SPAN_W      = LEN_W + 14;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [31:0]       r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W:0]    r_cnt;
    logic [1:0]        r_resp;

    logic              w_req_hs;
    logic              w_cross;
    logic              w_at_last;
    logic              w_r_hs;
    logic              w_w_hs;
    logic              w_rlast_err;
    logic [SPAN_W-1:0] w_end_addr;
    logic              w_unused;

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign w_req_hs    = req_valid && req_ready;
    // Burst end (exclusive) must not pass the next 4KB page boundary
    assign w_end_addr  = SPAN_W'({req_addr[11:2], 2'b00})
                       + ((SPAN_W'(req_len) + SPAN_W'(1)) << 2);
    assign w_cross     = w_end_addr > SPAN_W'(4096);
    assign w_at_last   = (r_cnt == {1'b0, r_len});
    assign w_r_hs      = (r_state == S_R) && RVALID && rd_ready;
    assign w_w_hs      = (r_state == S_W) && wr_valid && WREADY;
    assign w_rlast_err = (RLAST != w_at_last);
    assign w_unused    = ^{RID, BID, req_addr[1:0]};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_req_hs) w_next = w_cross ? S_ERR : (req_write ? S_AW : S_AR);
            S_AR:   if (ARREADY) w_next = S_R;
            S_R:    if (w_r_hs && w_at_last) w_next = S_DONE;
            S_AW:   if (AWREADY) w_next = S_W;
            S_W:    if (w_w_hs && w_at_last) w_next = S_B;
            S_B:    if (BVALID) w_next = S_DONE;
            S_ERR:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_addr <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_resp <= RESP_OKAY;
        end else begin
            if (w_req_hs) begin
                r_addr <= {req_addr[31:2], 2'b00};
                r_len  <= req_len;
                r_cnt  <= '0;
                r_resp <= w_cross ? RESP_SLVERR : RESP_OKAY;
            end
            if (w_r_hs) begin
                r_cnt  <= r_cnt + (LEN_W+1)'(1);
                r_resp <= resp_max(r_resp, resp_max(RRESP, w_rlast_err ? RESP_SLVERR : RESP_OKAY));
            end
            if (w_w_hs) begin
                r_cnt <= r_cnt + (LEN_W+1)'(1);
            end
            if ((r_state == S_B) && BVALID) begin
                r_resp <= resp_max(r_resp, BRESP);
            end
        end
    end

    always_comb begin
        req_ready = (r_state == S_IDLE) && !ARESET;
        ARVALID   = (r_state == S_AR);
        RREADY    = (r_state == S_R) && rd_ready;
        rd_valid  = (r_state == S_R) && RVALID;
        AWVALID   = (r_state == S_AW);
        WVALID    = (r_state == S_W) && wr_valid;
        wr_ready  = (r_state == S_W) && WREADY;
        WLAST     = (r_state == S_W) && w_at_last;
        BREADY    = (r_state == S_B);
        done      = (r_state == S_DONE);
        done_resp = (r_state == S_DONE) ? r_resp : RESP_OKAY;
    end

    assign ARID    = ID_W'(MASTER_ID);
    assign ARADDR  = r_addr;
    assign ARLEN   = r_len;
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;
    assign AWID    = ID_W'(MASTER_ID);
    assign AWADDR  = r_addr;
    assign AWLEN   = r_len;
    assign AWSIZE  = 3'b010;
    assign AWBURST = 2'b01;
    assign WDATA   = wr_data;
    assign WSTRB   = wr_strb;
    assign rd_data = RDATA;
    assign rd_last = RLAST;

endmodule
`default_nettype wire
